// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the icache and dcache miss paths.
// dcache has fixed priority; a starvation counter forces an icache grant after STARVE_LIMIT dcache wins.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ic_req_valid,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_rsp_valid,
  output logic [LINE_WIDTH-1:0] ic_rsp_data,
  input  logic                  dc_req_valid,
  input  logic                  dc_req_wr,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic [LINE_WIDTH-1:0] dc_req_data,
  output logic                  dc_rsp_valid,
  output logic [LINE_WIDTH-1:0] dc_rsp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wr,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_data,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          owner_ic;
  logic          pick_ic;
  always_comb pick_ic = ic_req_valid && (!dc_req_valid || starve_cnt == LIMIT);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      owner_ic      <= 1'b0;
      ic_rsp_valid  <= 1'b0;
      ic_rsp_data   <= '0;
      dc_rsp_valid  <= 1'b0;
      dc_rsp_data   <= '0;
      mem_req_valid <= 1'b0;
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
    end else begin
      case (state)
        IDLE: if (ic_req_valid || dc_req_valid) begin
          owner_ic      <= pick_ic;
          mem_req_valid <= 1'b1;
          mem_req_wr    <= pick_ic ? 1'b0 : dc_req_wr;
          mem_req_addr  <= pick_ic ? ic_req_addr : dc_req_addr;
          mem_req_data  <= pick_ic ? '0 : dc_req_data;
          // only a dcache win over a waiting icache counts toward starvation
          starve_cnt    <= (pick_ic || !ic_req_valid) ? '0 : starve_cnt + CW'(starve_cnt != LIMIT);
          state         <= REQ;
        end
        REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= WAIT;
        end
        WAIT: if (mem_rsp_valid) begin
          if (owner_ic) ic_rsp_data <= mem_rsp_data;
          else dc_rsp_data <= mem_rsp_data;
          ic_rsp_valid <= owner_ic;
          dc_rsp_valid <= !owner_ic;
          state        <= RESP;
        end
        RESP: begin
          ic_rsp_valid <= 1'b0;
          dc_rsp_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule
